// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (also used by the transmitter) and the
// default oversampling ratio.
package uart_pkg;

   localparam int unsigned OversampleDefault = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StStart = 2'b01,
      StData  = 2'b10,
      StStop  = 2'b11
   } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a selectable reset value.
module uart_sync2 #(
   parameter logic ResetVal = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {2{ResetVal}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with OVERSAMPLE x clock-enable sampling and a rdy/rdy_clr handshake.
// Defining UART_RX_FERR_EN adds the ferr port, a one-cycle pulse on a bad stop bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OversampleDefault
) (
   input  logic       clk_50m,
   input  logic       rst_n,
   input  logic       clken,
   input  logic       rx,
   input  logic       rdy_clr,
   output logic [7:0] data,
   output logic       rdy,
   output logic       overrun
`ifdef UART_RX_FERR_EN
   ,
   output logic       ferr
`endif
);

   localparam int unsigned SmpW = $clog2(OVERSAMPLE);
   localparam logic [SmpW-1:0] SmpMid  = SmpW'(OVERSAMPLE / 2 - 1);
   localparam logic [SmpW-1:0] SmpLast = SmpW'(OVERSAMPLE - 1);

   logic rx_s;

   uart_state_e     state_q, state_d;
   logic [SmpW-1:0] smp_q, smp_d;
   logic [2:0]      bitpos_q, bitpos_d;
   logic [7:0]      scratch_q, scratch_d;
   logic [7:0]      data_q, data_d;
   logic            rdy_q, rdy_d;
   logic            ovr_q, ovr_d;
`ifdef UART_RX_FERR_EN
   logic            stop_bad;
`endif

   uart_sync2 #(
      .ResetVal (1'b1)
   ) u_sync (
      .clk_i  (clk_50m),
      .rst_ni (rst_n),
      .d_i    (rx),
      .q_o    (rx_s)
   );

   always_comb begin
      state_d   = state_q;
      smp_d     = smp_q;
      bitpos_d  = bitpos_q;
      scratch_d = scratch_q;
      data_d    = data_q;
      rdy_d     = rdy_q;
      ovr_d     = ovr_q;
`ifdef UART_RX_FERR_EN
      stop_bad  = 1'b0;
`endif

      if (rdy_clr) begin
         rdy_d = 1'b0;
         ovr_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (clken && !rx_s) begin
               state_d = StStart;
               smp_d   = '0;
            end
         end
         StStart: begin
            // A start bit that does not stay low until its midpoint is treated as a glitch.
            if (clken) begin
               if (rx_s) begin
                  state_d = StIdle;
               end else if (smp_q == SmpMid) begin
                  state_d  = StData;
                  smp_d    = '0;
                  bitpos_d = 3'd0;
               end else begin
                  smp_d = smp_q + 1'b1;
               end
            end
         end
         StData: begin
            if (clken) begin
               smp_d = smp_q + 1'b1;
               if (smp_q == SmpLast) begin
                  scratch_d[bitpos_q] = rx_s;
                  smp_d               = '0;
                  if (bitpos_q == 3'd7) begin
                     state_d = StStop;
                  end else begin
                     bitpos_d = bitpos_q + 3'd1;
                  end
               end
            end
         end
         StStop: begin
            if (clken) begin
               smp_d = smp_q + 1'b1;
               if (smp_q == SmpLast) begin
                  state_d = StIdle;
                  smp_d   = '0;
                  if (rx_s) begin
                     // Completion beats a simultaneous rdy_clr.
                     data_d = scratch_q;
                     rdy_d  = 1'b1;
                     ovr_d  = rdy_clr ? 1'b0 : (ovr_q | rdy_q);
                  end else begin
`ifdef UART_RX_FERR_EN
                     stop_bad = 1'b1;
`endif
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         smp_q     <= '0;
         bitpos_q  <= 3'd0;
         scratch_q <= 8'h00;
         data_q    <= 8'h00;
         rdy_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         smp_q     <= smp_d;
         bitpos_q  <= bitpos_d;
         scratch_q <= scratch_d;
         data_q    <= data_d;
         rdy_q     <= rdy_d;
         ovr_q     <= ovr_d;
      end
   end

`ifdef UART_RX_FERR_EN
   logic ferr_q;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         ferr_q <= 1'b0;
      end else begin
         ferr_q <= stop_bad;
      end
   end

   assign ferr = ferr_q;
`else
   // Without the error port a bad stop bit simply drops the frame.
`endif

   assign data    = data_q;
   assign rdy     = rdy_q;
   assign overrun = ovr_q;

endmodule
